// File: rtl/hamming_enc_arbiter.sv
// Round-robin front end that shares one combinational Hamming encoder between
// NUM_REQ requesters. Two register stages: A drives the encoder, B holds the codeword.
module hamming_enc_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   // Check bits r: smallest r with 2**r >= DATA_WIDTH + r + 1; one extra overall parity bit.
   localparam int CHECK_BITS  = (DATA_WIDTH <= 1)   ? 2 :
                                (DATA_WIDTH <= 4)   ? 3 :
                                (DATA_WIDTH <= 11)  ? 4 :
                                (DATA_WIDTH <= 26)  ? 5 :
                                (DATA_WIDTH <= 57)  ? 6 :
                                (DATA_WIDTH <= 120) ? 7 :
                                (DATA_WIDTH <= 247) ? 8 : 9,
   localparam int CODED_WIDTH = DATA_WIDTH + CHECK_BITS + 1,
   localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_REQ-1:0]              cfg_en_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   output logic                            enc_valid_o,
   output logic [DATA_WIDTH-1:0]           enc_data_o,
   input  logic [CODED_WIDTH-1:0]          enc_code_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [CODED_WIDTH-1:0]          out_code_o,
   output logic [ID_WIDTH-1:0]             out_id_o
);

   logic [NUM_REQ-1:0]     eligible;
   logic                   win_found;
   logic [ID_WIDTH-1:0]    win_idx;
   logic [DATA_WIDTH-1:0]  win_data;
   logic                   a_free;
   logic                   b_free;
   logic                   accept;

   logic                   enc_valid_q, enc_valid_d;
   logic [DATA_WIDTH-1:0]  enc_data_q,  enc_data_d;
   logic [ID_WIDTH-1:0]    a_id_q,      a_id_d;
   logic                   out_valid_q, out_valid_d;
   logic [CODED_WIDTH-1:0] out_code_q,  out_code_d;
   logic [ID_WIDTH-1:0]    out_id_q,    out_id_d;
   logic [ID_WIDTH-1:0]    rr_ptr_q,    rr_ptr_d;

   assign eligible = req_valid_i & cfg_en_i;
   assign b_free   = !out_valid_q || out_ready_i;
   assign a_free   = !enc_valid_q || b_free;

   // Scan starting at rr_ptr, wrapping modulo NUM_REQ; first eligible index wins.
   always_comb begin
      int unsigned idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!win_found && eligible[ID_WIDTH'(idx)]) begin
            win_found = 1'b1;
            win_idx   = ID_WIDTH'(idx);
         end
      end
   end

   assign win_data = req_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign accept   = win_found && a_free && !rst_i;

   always_comb begin
      req_ready_o = '0;
      if (accept) begin
         req_ready_o[win_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_id_d    = out_id_q;
      if (b_free) begin
         out_valid_d = enc_valid_q;
         out_code_d  = enc_code_i;
         out_id_d    = a_id_q;
      end
   end

   // An empty slot keeps its stale payload; only the valid flag is cleared.
   always_comb begin
      enc_valid_d = enc_valid_q;
      enc_data_d  = enc_data_q;
      a_id_d      = a_id_q;
      if (a_free) begin
         enc_valid_d = win_found;
         if (win_found) begin
            enc_data_d = win_data;
            a_id_d     = win_idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enc_valid_q <= 1'b0;
         enc_data_q  <= '0;
         a_id_q      <= '0;
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         enc_valid_q <= enc_valid_d;
         enc_data_q  <= enc_data_d;
         a_id_q      <= a_id_d;
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_id_q    <= out_id_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign enc_valid_o = enc_valid_q;
   assign enc_data_o  = enc_data_q;
   assign out_valid_o = out_valid_q;
   assign out_code_o  = out_code_q;
   assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Bench for hamming_enc_arbiter at NUM_REQ=4, DATA_WIDTH=4 with an encoder stub
// returning {4'b0, enc_data_o}; a slot-level reference model tracks expected state.
module tb_hamming_enc_arbiter;
   localparam int NR = 4;
   localparam int DW = 4;
   localparam int CW = 8;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   cfg_en;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            enc_valid;
   logic [DW-1:0]   enc_data;
   logic [CW-1:0]   enc_code;
   logic            out_valid;
   logic            out_ready;
   logic [CW-1:0]   out_code;
   logic [IW-1:0]   out_id;

   int n_vec = 0;
   int n_err = 0;

   // reference model: two slots (encoder input, output) plus pointer
   int          m_rr;
   bit          mA_v, mB_v;
   logic [DW-1:0] mA_d;
   int          mA_id, mB_id;
   logic [CW-1:0] mB_code;
   int          m_win;
   bit          m_afree, m_bfree;
   logic [NR-1:0] exp_ready;

   always #5 clk = ~clk;
   assign enc_code = {4'b0, enc_data};

   hamming_enc_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .req_valid_i(req_valid),
      .req_data_i(req_data), .req_ready_o(req_ready), .enc_valid_o(enc_valid),
      .enc_data_o(enc_data), .enc_code_i(enc_code), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_code_o(out_code), .out_id_o(out_id)
   );

   task automatic model_comb();
      int i;
      m_bfree = !mB_v || out_ready;
      m_afree = !mA_v || m_bfree;
      m_win = -1;
      for (int k = 0; k < NR; k++) begin
         i = (m_rr + k) % NR;
         if (m_win < 0 && req_valid[i] && cfg_en[i]) m_win = i;
      end
      exp_ready = '0;
      if (!rst && m_win >= 0 && m_afree) exp_ready[m_win] = 1'b1;
   endtask

   task automatic model_seq();
      if (rst) begin
         m_rr = 0; mA_v = 0; mB_v = 0; mA_d = '0; mA_id = 0; mB_id = 0; mB_code = '0;
      end else begin
         if (m_bfree) begin
            mB_v = mA_v; mB_code = {4'b0, mA_d}; mB_id = mA_id;
         end
         if (m_afree) begin
            mA_v = (m_win >= 0);
            if (m_win >= 0) begin
               mA_d = req_data[m_win*DW +: DW];
               mA_id = m_win;
               m_rr = (m_win + 1) % NR;
            end
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_comb();
   endtask

   task automatic tick();
      model_seq();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      settle();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_en = '1; req_valid = '1; req_data = 16'h4321; out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         settle();
         n_vec++;
         if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready c=%0d got=%b exp=0000", c, req_ready);
         end
         tick();
      end
      rst = 1'b0; req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_vec++;
         if ({req_ready, enc_valid, enc_data, out_valid, out_code, out_id} !== '0) begin
            n_err++;
            $display("FAIL reset_idle c=%0d got rdy=%b ev=%b ed=%h ov=%b oc=%h oid=%0d exp all 0",
                     c, req_ready, enc_valid, enc_data, out_valid, out_code, out_id);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      cfg_en = '1; out_ready = 1'b1; req_valid = 4'b0100; req_data = 16'h0A00;
      settle();
      n_vec++;
      if (req_ready !== 4'b0100) begin
         n_err++; $display("FAIL single_ready got=%b exp=0100", req_ready);
      end
      tick();
      req_valid = '0;
      settle();
      n_vec++;
      if (enc_valid !== 1'b1 || enc_data !== 4'hA || out_valid !== 1'b0) begin
         n_err++; $display("FAIL single_stageA got ev=%b ed=%h ov=%b exp 1 a 0", enc_valid, enc_data, out_valid);
      end
      tick();
      settle();
      n_vec++;
      if (out_valid !== 1'b1 || out_code !== 8'h0A || out_id !== 2'd2) begin
         n_err++; $display("FAIL single_out got ov=%b oc=%h id=%0d exp 1 0a 2", out_valid, out_code, out_id);
      end
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      cfg_en = '1; out_ready = 1'b1; req_valid = '1; req_data = 16'h4321;
      for (int k = 0; k < 12; k++) begin
         settle();
         n_vec++;
         if (req_ready !== 4'(1 << (k % 4))) begin
            n_err++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
         end
         if (k >= 2) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_id !== 2'((k - 2) % 4) || out_code !== 8'((k - 2) % 4 + 1)) begin
               n_err++; $display("FAIL rr_out k=%0d got ov=%b id=%0d oc=%h exp 1 %0d %0d",
                                 k, out_valid, out_id, out_code, (k - 2) % 4, (k - 2) % 4 + 1);
            end
         end
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [NR-1:0] exp_g [3] = '{4'b0001, 4'b0010, 4'b0000};
      do_reset();
      cfg_en = '1; out_ready = 1'b0; req_valid = 4'b0011; req_data = 16'h0021;
      for (int k = 0; k < 5; k++) begin
         settle();
         n_vec++;
         if (req_ready !== exp_g[(k < 2) ? k : 2]) begin
            n_err++; $display("FAIL bp_grant k=%0d got=%b exp=%b", k, req_ready, exp_g[(k < 2) ? k : 2]);
         end
         if (k >= 2) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_code !== 8'h01 || out_id !== 2'd0) begin
               n_err++; $display("FAIL bp_hold k=%0d got ov=%b oc=%h id=%0d exp 1 01 0", k, out_valid, out_code, out_id);
            end
         end
         tick();
      end
      out_ready = 1'b1; req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_vec++;
         if ((k < 2 && (out_valid !== 1'b1 || out_code !== 8'(k + 1) || out_id !== 2'(k))) ||
             (k == 2 && out_valid !== 1'b0)) begin
            n_err++; $display("FAIL bp_drain k=%0d got ov=%b oc=%h id=%0d", k, out_valid, out_code, out_id);
         end
         tick();
      end
   endtask

   task automatic test_cfg_mask();
      do_reset();
      cfg_en = 4'b1010; out_ready = 1'b1; req_valid = '1; req_data = 16'h4321;
      for (int k = 0; k < 6; k++) begin
         settle();
         n_vec++;
         if (req_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
            n_err++; $display("FAIL mask_grant k=%0d got=%b", k, req_ready);
         end
         if (k >= 2) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_id !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
               n_err++; $display("FAIL mask_out k=%0d got ov=%b id=%0d", k, out_valid, out_id);
            end
         end
         tick();
      end
      cfg_en = 4'b1011;
      for (int k = 0; k < 8; k++) begin
         settle();
         n_vec++;
         if (req_ready !== exp_ready || out_valid !== mB_v || (mB_v && out_id !== 2'(mB_id))) begin
            n_err++; $display("FAIL mask_enable k=%0d got rdy=%b ov=%b id=%0d exp rdy=%b ov=%b id=%0d",
                              k, req_ready, out_valid, out_id, exp_ready, mB_v, mB_id);
         end
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      cfg_en = '1; out_ready = 1'b0; req_valid = 4'b0011; req_data = 16'h0021;
      for (int k = 0; k < 3; k++) begin
         settle();
         tick();
      end
      settle();
      n_vec++;
      if (enc_valid !== 1'b1 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL mid_full got ev=%b ov=%b exp 1 1", enc_valid, out_valid);
      end
      tick();
      rst = 1'b1; out_ready = 1'b1;
      settle();
      n_vec++;
      if (req_ready !== 4'b0000) begin
         n_err++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
      end
      tick();
      rst = 1'b0; cfg_en = 4'b1100; req_valid = 4'b1110; req_data = 16'h7650;
      settle();
      n_vec++;
      if (out_valid !== 1'b0 || enc_valid !== 1'b0 || req_ready !== 4'b0100) begin
         n_err++; $display("FAIL mid_after got ov=%b ev=%b rdy=%b exp 0 0 0100", out_valid, enc_valid, req_ready);
      end
      tick();
      req_valid = '0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         rst       = ($urandom_range(0, 63) == 0);
         cfg_en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
         req_valid = 4'($urandom);
         req_data  = 16'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         settle();
         n_vec++;
         if (req_ready !== exp_ready || enc_valid !== mA_v || out_valid !== mB_v ||
             (mA_v && enc_data !== mA_d) ||
             (mB_v && (out_code !== mB_code || out_id !== 2'(mB_id)))) begin
            n_err++;
            $display("FAIL random k=%0d got rdy=%b ev=%b ed=%h ov=%b oc=%h id=%0d exp rdy=%b ev=%b ed=%h ov=%b oc=%h id=%0d",
                     k, req_ready, enc_valid, enc_data, out_valid, out_code, out_id,
                     exp_ready, mA_v, mA_d, mB_v, mB_code, mB_id);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_en = '0; req_valid = '0; req_data = '0; out_ready = 1'b0;
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_cfg_mask();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
